usrt_tx: RTL and testbench

Byte-serialising transmitter stage that consumes the bit-rate clock produced by baudgen (o_Bclk) and drives the serial line.
- Accepts one data word per valid/ready handshake.
- Frames it as start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
- Advances exactly one bit per rising edge of the bit clock, with all logic in the i_Pclk domain.

---
 rtl/usrt_tx_if.sv | 26 ++
 rtl/usrt_tx.sv | 162 ++++++++++++++++
 tb/tb_usrt_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/usrt_tx_if.sv
// Transmit-side handshake, frame configuration and serial line of usrt_tx.
interface usrt_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    // Producer of words and frame configuration.
    modport master (
        output tx_data, tx_valid, parity_en, parity_odd, two_stop,
        input  tx_ready, tx, busy, tx_done
    );

    // The transmitter itself.
    modport slave (
        input  tx_data, tx_valid, parity_en, parity_odd, two_stop,
        output tx_ready, tx, busy, tx_done
    );
endinterface

// File: rtl/usrt_tx.sv
// Byte-serialising transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits. One bit per rising edge of i_Bclk, which is a
// registered signal already synchronous to i_Pclk.
module usrt_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        i_Pclk,
    input  logic        i_Rst_n,
    input  logic        i_Bclk,
    usrt_tx_if.slave    tx_if
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_e;

    state_e                state_q, state_d;
    logic                  bclk_prev_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  parity_en_q, parity_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  tick;

    // One i_Pclk-cycle pulse per rising edge of the bit clock.
    assign tick = i_Bclk & ~bclk_prev_q;

    // State register; reset aborts a frame and returns the line high at once.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            bclk_prev_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_prev_q <= i_Bclk;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            parity_en_q <= parity_en_d;
            two_stop_q  <= two_stop_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    // Next-state and registered-output logic; all moves except accept wait for a tick.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        parity_en_d = parity_en_q;
        two_stop_d  = two_stop_q;
        parity_d    = parity_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A tick in the accept cycle is deliberately ignored.
                if (tx_if.tx_valid) begin
                    shift_d     = tx_if.tx_data;
                    parity_en_d = tx_if.parity_en;
                    two_stop_d  = tx_if.two_stop;
                    parity_d    = (^tx_if.tx_data) ^ tx_if.parity_odd;
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                    state_d     = S_SYNC;
                end
            end
            S_SYNC: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_BIT) begin
                        if (parity_en_q) begin
                            tx_d    = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (tick) begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_if.tx       = tx_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_done  = done_q;
endmodule

// File: tb/tb_usrt_tx.sv
// Directed bench for usrt_tx: frame vectors from a table plus hand-written
// sequences for back-to-back, mid-frame reset, stalled and re-timed bit clock.
module tb_usrt_tx;
    localparam int DW = 8;

    logic pclk;
    logic rst_n;
    logic bclk;
    int   bper;
    int   bcnt;
    bit   gen_en;
    int   n_cmp;
    int   n_fail;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        podd;
        logic        two;
        logic [11:0] bits;   // line values in transmit order, bit 0 first
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    usrt_tx_if #(.DATA_WIDTH(DW)) tx_if();

    usrt_tx #(.DATA_WIDTH(DW)) dut (
        .i_Pclk  (pclk),
        .i_Rst_n (rst_n),
        .i_Bclk  (bclk),
        .tx_if   (tx_if)
    );

    // System clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Bit clock, bper Pclk cycles per period, updated away from the active edge.
    initial begin
        bper   = 10;
        bcnt   = 0;
        bclk   = 1'b0;
        gen_en = 1'b1;
        forever begin
            @(negedge pclk);
            if (gen_en) begin
                bcnt = (bcnt + 1 >= bper) ? 0 : bcnt + 1;
                bclk = (bcnt < bper / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer a word, wait for the handshake, then scramble the inputs to show they are ignored.
    task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic two);
        int n;
        n = 0;
        tx_if.tx_data    = d;
        tx_if.parity_en  = pen;
        tx_if.parity_odd = podd;
        tx_if.two_stop   = two;
        tx_if.tx_valid   = 1'b1;
        while (tx_if.tx_ready !== 1'b1 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("accept_ready", tx_if.tx_ready, 1);
        @(negedge pclk);
        tx_if.tx_valid   = 1'b0;
        tx_if.tx_data    = ~d;
        tx_if.parity_en  = ~pen;
        tx_if.parity_odd = ~podd;
        tx_if.two_stop   = ~two;
        check("accept_busy", tx_if.busy, 1);
        check("accept_not_ready", tx_if.tx_ready, 0);
    endtask

    // Follow one frame: each bit must hold its value for a whole bit period,
    // then tx_done pulses once. From bit sw_bit on the bit clock period is p2.
    task automatic check_frame(input string name, input logic [11:0] bits, input int nbits,
                               input int sw_bit, input int p2, output int wait_cyc);
        int   p;
        logic got;
        p        = bper;
        wait_cyc = 0;
        while (tx_if.tx !== 1'b0 && wait_cyc < 200) begin
            @(negedge pclk);
            wait_cyc++;
        end
        check($sformatf("%s start", name), tx_if.tx, 0);
        if (tx_if.tx !== 1'b0) return;
        for (int i = 0; i < nbits; i++) begin
            if (i == sw_bit) p = p2;
            got = 1'bx;
            for (int k = 0; k < p; k++) begin
                if (!(i == 0 && k == 0)) @(negedge pclk);
                if (i == sw_bit && k == 0) bper = p2;
                if (k == 0 || tx_if.tx !== bits[i]) got = tx_if.tx;
                if (tx_if.tx_done !== 1'b0) got = 1'bx;
            end
            check($sformatf("%s bit%0d", name, i), got, bits[i]);
        end
        @(negedge pclk);
        check($sformatf("%s done", name), tx_if.tx_done, 1);
        check($sformatf("%s ready", name), tx_if.tx_ready, 1);
        check($sformatf("%s idle", name), tx_if.busy, 0);
        @(negedge pclk);
        check($sformatf("%s done_pulse", name), tx_if.tx_done, 0);
    endtask

    initial begin
        int w;
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'h34A, 10};  // 8N1
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'h60E, 11};  // 8E1, parity 1
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 12'h40E, 11};  // 8O1, parity 0
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 12'h400, 11};  // 8E1, parity 0
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 12'h7FE, 11};  // 8N2
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 12'h600, 11};  // 8O1, parity 1

        rst_n            = 1'b0;
        tx_if.tx_data    = '0;
        tx_if.tx_valid   = 1'b0;
        tx_if.parity_en  = 1'b0;
        tx_if.parity_odd = 1'b0;
        tx_if.two_stop   = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_tx", tx_if.tx, 1);
        check("rst_ready", tx_if.tx_ready, 1);
        check("rst_busy", tx_if.busy, 0);
        check("rst_done", tx_if.tx_done, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].two);
            check_frame($sformatf("vec%0d", i), vecs[i].bits, vecs[i].nbits, -1, 0, w);
            repeat (5) @(negedge pclk);
        end

        // Bit clock stalled: an accepted word waits in SYNC with the line high.
        gen_en = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge pclk);
        check("stall_line", tx_if.tx, 1);
        check("stall_busy", tx_if.busy, 1);
        gen_en = 1'b1;
        check_frame("stall_frame", 12'h34A, 10, -1, 0, w);

        // Valid held high across two words: both sent once, short gap between.
        tx_if.parity_en  = 1'b0;
        tx_if.parity_odd = 1'b0;
        tx_if.two_stop   = 1'b0;
        tx_if.tx_data    = 8'h11;
        tx_if.tx_valid   = 1'b1;
        w = 0;
        while (tx_if.tx_ready !== 1'b1 && w < 200) begin
            @(negedge pclk);
            w++;
        end
        check("b2b_ready", tx_if.tx_ready, 1);
        @(negedge pclk);
        tx_if.tx_data = 8'h22;
        check_frame("b2b_0x11", 12'h222, 10, -1, 0, w);
        tx_if.tx_valid = 1'b0;
        check("b2b_second_taken", tx_if.busy, 1);
        check_frame("b2b_0x22", 12'h244, 10, -1, 0, w);
        check("b2b_gap", (w <= bper), 1);
        repeat (25) @(negedge pclk);
        check("b2b_no_dup_line", tx_if.tx, 1);
        check("b2b_no_dup_busy", tx_if.busy, 0);

        // Reset during data bit 3 aborts the frame at once.
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        w = 0;
        while (tx_if.tx !== 1'b0 && w < 200) begin
            @(negedge pclk);
            w++;
        end
        check("rst_mid_start", tx_if.tx, 0);
        repeat (4 * bper + 2) @(negedge pclk);
        check("rst_mid_d3", tx_if.tx, 1);
        check("rst_mid_busy_before", tx_if.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_if.tx, 1);
        check("rst_mid_ready", tx_if.tx_ready, 1);
        check("rst_mid_busy", tx_if.busy, 0);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (2) @(negedge pclk);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        check_frame("rst_resend", 12'h278, 10, -1, 0, w);

        // Bit clock period drops from 10 to 4 Pclk from data bit 3 onward.
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        check_frame("rate_switch", 12'h34A, 10, 4, 4, w);
        repeat (20) @(negedge pclk);
        check("rate_switch_single_done", tx_if.tx_done, 0);
        bper = 10;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
